memory_bus_master: RTL and testbench

- Initiator side of the main-memory bus; the CPU datapath and fetch unit use it to reach main memory.
- Accepts one single-word read or write command at a time from the core.
- Drives address, write data and the RD/WR strobes onto the memory bus, then holds them until the memory returns ACK or a timeout expires.
- Returns read data plus a one-cycle done pulse, with an error flag on timeout or misaligned address.

---
 rtl/memory_bus_master_pkg.sv | 23 ++
 rtl/memory_bus_timeout_counter.sv | 32 +++
 rtl/memory_bus_master.sv | 123 ++++++++++++
 tb/tb_memory_bus_master.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_bus_master_pkg.sv
// Shared definitions for the main-memory bus initiator: FSM state encoding,
// command encoding and the default bus width.
package memory_bus_master_pkg;

  localparam int DATAWIDTH_BUS_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_ACK = 2'b01,
    ST_RESP     = 2'b10
  } state_t;

  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } cmd_t;

  // A bus access is legal only on a word boundary.
  function automatic logic is_word_aligned(input logic [1:0] addr_low);
    return (addr_low == 2'b00);
  endfunction

endpackage

// File: rtl/memory_bus_timeout_counter.sv
// Saturating wait counter for the bus master. Cleared while idle, counts each
// strobe cycle without ACK, flags the last permitted cycle and never wraps.
// TIMEOUT_CYCLES must be at least 2 and fit in TO_CNT_W bits.
module memory_bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_CNT_W       = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [TO_CNT_W-1:0] TC_VALUE = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TO_CNT_W-1:0] count;

  // Count wait cycles, holding at the terminal value instead of wrapping.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of its neighbours.
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != TC_VALUE)) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == TC_VALUE);

endmodule

// File: rtl/memory_bus_master.sv
// Main-memory bus initiator. Takes one single-word read or write from the core,
// drives it onto the bus until ACK or timeout, then reports read data, a
// one-cycle DONE pulse and an error flag. Every output comes from a register.
module memory_bus_master
  import memory_bus_master_pkg::*;
#(
  parameter int DATAWIDTH_BUS  = DATAWIDTH_BUS_DEFAULT,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_CNT_W       = 5
) (
  input  logic                     MEMORY_BUS_MASTER_CLOCK_50,
  input  logic                     MEMORY_BUS_MASTER_RESET_InHigh,
  input  logic                     MEMORY_BUS_MASTER_START_In,
  input  logic                     MEMORY_BUS_MASTER_WE_In,
  input  logic [DATAWIDTH_BUS-1:0] MEMORY_BUS_MASTER_ADDR_InBUS,
  input  logic [DATAWIDTH_BUS-1:0] MEMORY_BUS_MASTER_WDATA_InBUS,
  output logic [DATAWIDTH_BUS-1:0] MEMORY_BUS_MASTER_RDATA_OutBUS,
  output logic                     MEMORY_BUS_MASTER_BUSY_Out,
  output logic                     MEMORY_BUS_MASTER_DONE_Out,
  output logic                     MEMORY_BUS_MASTER_ERR_Out,
  output logic [DATAWIDTH_BUS-1:0] MEMORY_BUS_MASTER_MEM_ADDRESS_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] MEMORY_BUS_MASTER_MEM_data_OutBUS,
  output logic                     MEMORY_BUS_MASTER_MEM_RD_Out,
  output logic                     MEMORY_BUS_MASTER_MEM_WR_Out,
  input  logic [DATAWIDTH_BUS-1:0] MEMORY_BUS_MASTER_MEM_data_InBUS,
  input  logic                     MEMORY_BUS_MASTER_MEM_ACK_In
);

  state_t state;
  cmd_t   cmd;
  logic   cnt_clear;
  logic   cnt_enable;
  logic   cnt_terminal;

  assign cmd        = cmd_t'(MEMORY_BUS_MASTER_WE_In);
  assign cnt_clear  = (state == ST_IDLE);
  assign cnt_enable = (state == ST_WAIT_ACK) && !MEMORY_BUS_MASTER_MEM_ACK_In;

  memory_bus_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_CNT_W       (TO_CNT_W)
  ) u_timeout_counter (
    .clk      (MEMORY_BUS_MASTER_CLOCK_50),
    .rst      (MEMORY_BUS_MASTER_RESET_InHigh),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .terminal (cnt_terminal)
  );

  // Transaction FSM; all bus and core-side outputs are registered here.
  always_ff @(posedge MEMORY_BUS_MASTER_CLOCK_50) begin
    if (MEMORY_BUS_MASTER_RESET_InHigh) begin
      state                                <= ST_IDLE;
      MEMORY_BUS_MASTER_RDATA_OutBUS       <= '0;
      MEMORY_BUS_MASTER_BUSY_Out           <= 1'b0;
      MEMORY_BUS_MASTER_DONE_Out           <= 1'b0;
      MEMORY_BUS_MASTER_ERR_Out            <= 1'b0;
      MEMORY_BUS_MASTER_MEM_ADDRESS_OutBUS <= '0;
      MEMORY_BUS_MASTER_MEM_data_OutBUS    <= '0;
      MEMORY_BUS_MASTER_MEM_RD_Out         <= 1'b0;
      MEMORY_BUS_MASTER_MEM_WR_Out         <= 1'b0;
    end else begin
      // DONE is a single-cycle pulse; only a completing transition raises it.
      MEMORY_BUS_MASTER_DONE_Out <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (MEMORY_BUS_MASTER_START_In) begin
            MEMORY_BUS_MASTER_BUSY_Out <= 1'b1;
            if (is_word_aligned(MEMORY_BUS_MASTER_ADDR_InBUS[1:0])) begin
              MEMORY_BUS_MASTER_MEM_ADDRESS_OutBUS <= MEMORY_BUS_MASTER_ADDR_InBUS;
              MEMORY_BUS_MASTER_MEM_data_OutBUS    <= MEMORY_BUS_MASTER_WDATA_InBUS;
              MEMORY_BUS_MASTER_MEM_RD_Out         <= (cmd == CMD_READ);
              MEMORY_BUS_MASTER_MEM_WR_Out         <= (cmd == CMD_WRITE);
              state                                <= ST_WAIT_ACK;
            end else begin
              // Misaligned: never touches the bus, completes with an error.
              MEMORY_BUS_MASTER_ERR_Out      <= 1'b1;
              MEMORY_BUS_MASTER_RDATA_OutBUS <= '0;
              MEMORY_BUS_MASTER_DONE_Out     <= 1'b1;
              state                          <= ST_RESP;
            end
          end
        end

        ST_WAIT_ACK: begin
          if (MEMORY_BUS_MASTER_MEM_ACK_In) begin
            // Writes leave RDATA at whatever the last read returned.
            if (MEMORY_BUS_MASTER_MEM_RD_Out) begin
              MEMORY_BUS_MASTER_RDATA_OutBUS <= MEMORY_BUS_MASTER_MEM_data_InBUS;
            end
            MEMORY_BUS_MASTER_MEM_RD_Out <= 1'b0;
            MEMORY_BUS_MASTER_MEM_WR_Out <= 1'b0;
            MEMORY_BUS_MASTER_ERR_Out    <= 1'b0;
            MEMORY_BUS_MASTER_DONE_Out   <= 1'b1;
            state                        <= ST_RESP;
          end else if (cnt_terminal) begin
            MEMORY_BUS_MASTER_MEM_RD_Out   <= 1'b0;
            MEMORY_BUS_MASTER_MEM_WR_Out   <= 1'b0;
            MEMORY_BUS_MASTER_ERR_Out      <= 1'b1;
            MEMORY_BUS_MASTER_RDATA_OutBUS <= '0;
            MEMORY_BUS_MASTER_DONE_Out     <= 1'b1;
            state                          <= ST_RESP;
          end
        end

        ST_RESP: begin
          // START and ACK are both ignored here; ERR and RDATA keep their values.
          MEMORY_BUS_MASTER_BUSY_Out <= 1'b0;
          state                      <= ST_IDLE;
        end

        default: begin
          MEMORY_BUS_MASTER_BUSY_Out   <= 1'b0;
          MEMORY_BUS_MASTER_MEM_RD_Out <= 1'b0;
          MEMORY_BUS_MASTER_MEM_WR_Out <= 1'b0;
          state                        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_bus_master.sv
// Self-checking bench for memory_bus_master: directed scenarios followed by
// random commands, all judged against a transaction-level reference model.
module tb_memory_bus_master;

  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          we;
  logic [DW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  always #5 clk = ~clk;

  memory_bus_master #(
    .DATAWIDTH_BUS  (DW),
    .TIMEOUT_CYCLES (TO),
    .TO_CNT_W       (5)
  ) dut (
    .MEMORY_BUS_MASTER_CLOCK_50           (clk),
    .MEMORY_BUS_MASTER_RESET_InHigh       (rst),
    .MEMORY_BUS_MASTER_START_In           (start),
    .MEMORY_BUS_MASTER_WE_In              (we),
    .MEMORY_BUS_MASTER_ADDR_InBUS         (addr),
    .MEMORY_BUS_MASTER_WDATA_InBUS        (wdata),
    .MEMORY_BUS_MASTER_RDATA_OutBUS       (rdata),
    .MEMORY_BUS_MASTER_BUSY_Out           (busy),
    .MEMORY_BUS_MASTER_DONE_Out           (done),
    .MEMORY_BUS_MASTER_ERR_Out            (err),
    .MEMORY_BUS_MASTER_MEM_ADDRESS_OutBUS (mem_addr),
    .MEMORY_BUS_MASTER_MEM_data_OutBUS    (mem_wdata),
    .MEMORY_BUS_MASTER_MEM_RD_Out         (mem_rd),
    .MEMORY_BUS_MASTER_MEM_WR_Out         (mem_wr),
    .MEMORY_BUS_MASTER_MEM_data_InBUS     (mem_rdata),
    .MEMORY_BUS_MASTER_MEM_ACK_In         (mem_ack)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: memory contents and the core-visible result registers.
  logic [DW-1:0] ref_mem [bit [31:0]];
  logic [DW-1:0] exp_rdata;
  logic          exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Issue one command; memory acks on the hold-th strobe cycle (hold > TO never acks).
  // With poke set, a stray START pulse is driven while the command is in flight.
  task automatic run_cmd(input string tag, input logic cmd_we, input logic [31:0] cmd_addr,
                         input logic [31:0] cmd_wdata, input int hold, input bit poke);
    int            exp_strobe;
    int            exp_lat;
    int            strobe_cnt;
    int            done_at;
    int            j;
    logic [DW-1:0] rd_val;

    if (cmd_addr[1:0] != 2'b00) begin
      exp_strobe = 0;
      exp_lat    = 1;
      exp_err    = 1'b1;
      exp_rdata  = '0;
    end else if (hold <= TO) begin
      exp_strobe = hold;
      exp_lat    = hold + 1;
      exp_err    = 1'b0;
      if (!cmd_we) begin
        if (!ref_mem.exists(cmd_addr)) ref_mem[cmd_addr] = $urandom;
        exp_rdata = ref_mem[cmd_addr];
      end
    end else begin
      exp_strobe = TO;
      exp_lat    = TO + 1;
      exp_err    = 1'b1;
      exp_rdata  = '0;
    end
    rd_val = ref_mem.exists(cmd_addr) ? ref_mem[cmd_addr] : $urandom;

    start = 1'b1;
    we    = cmd_we;
    addr  = cmd_addr;
    wdata = cmd_wdata;

    strobe_cnt = 0;
    done_at    = -1;
    j          = 0;
    while (done_at < 0 && j < 40) begin
      @(negedge clk);
      j++;
      if (j == 1) begin
        // Scramble the command inputs to prove the bus side was latched.
        we    = 1'($urandom);
        addr  = $urandom;
        wdata = $urandom;
      end
      chkb({tag, " rd_wr_exclusive"}, mem_rd & mem_wr, 1'b0);
      if (mem_rd || mem_wr) begin
        strobe_cnt++;
        chk({tag, " strobe_kind"}, 32'({mem_rd, mem_wr}), cmd_we ? 32'd1 : 32'd2);
        chk({tag, " bus_addr"}, mem_addr, cmd_addr);
        if (cmd_we) chk({tag, " bus_wdata"}, mem_wdata, cmd_wdata);
      end
      if (done) begin
        done_at = j;
        chkb({tag, " busy_at_done"}, busy, 1'b1);
      end else begin
        chkb({tag, " busy_in_flight"}, busy, 1'b1);
      end
      mem_ack   = (mem_rd || mem_wr) && (strobe_cnt == hold) && !done;
      mem_rdata = mem_ack ? rd_val : $urandom;
      if (mem_ack && cmd_we) ref_mem[cmd_addr] = cmd_wdata;
      start = poke && (j == 2);
    end
    start   = 1'b0;
    mem_ack = 1'b0;

    chk({tag, " latency"}, 32'(done_at), 32'(exp_lat));
    chk({tag, " strobe_cycles"}, 32'(strobe_cnt), 32'(exp_strobe));
    chkb({tag, " err"}, err, exp_err);
    chk({tag, " rdata"}, rdata, exp_rdata);

    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      chkb({tag, " post_done"}, done, 1'b0);
      chkb({tag, " post_busy"}, busy, 1'b0);
      chkb({tag, " post_strobe"}, mem_rd | mem_wr, 1'b0);
      chkb({tag, " post_err_hold"}, err, exp_err);
      chk({tag, " post_rdata_hold"}, rdata, exp_rdata);
    end
  endtask

  initial begin
    int          rises;
    int          done1;
    int          rise2;
    int          n_done;
    logic        prev_rd;
    logic [31:0] raddr;

    rst       = 1'b1;
    start     = 1'b0;
    we        = 1'b0;
    addr      = '0;
    wdata     = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    exp_rdata = '0;
    exp_err   = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    chkb("reset busy", busy, 1'b0);
    chkb("reset done", done, 1'b0);
    chkb("reset err", err, 1'b0);
    chk("reset rdata", rdata, '0);
    chk("reset mem_addr", mem_addr, '0);
    chk("reset mem_wdata", mem_wdata, '0);
    chkb("reset rd", mem_rd, 1'b0);
    chkb("reset wr", mem_wr, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Directed scenarios.
    ref_mem[32'h804] = 32'hC600_2001;
    run_cmd("read", 1'b0, 32'h804, 32'h0, 2, 1'b0);
    run_cmd("write", 1'b1, 32'h810, 32'h8200_4002, 1, 1'b0);
    run_cmd("timeout", 1'b0, 32'h830, 32'h0, 1000, 1'b0);

    // A late ACK arriving in IDLE must change nothing.
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chkb("late_ack done", done, 1'b0);
    chkb("late_ack busy", busy, 1'b0);
    chkb("late_ack strobe", mem_rd | mem_wr, 1'b0);
    chkb("late_ack err", err, 1'b1);
    chk("late_ack rdata", rdata, '0);

    run_cmd("misaligned", 1'b0, 32'h806, 32'h0, 1, 1'b0);
    run_cmd("poke_in_wait", 1'b0, 32'h800, 32'h0, 5, 1'b1);

    // Back-to-back: START held high for reads of 0x800 then 0x804.
    ref_mem[32'h800] = 32'h1357_9BDF;
    ref_mem[32'h804] = 32'h2468_ACE0;
    start   = 1'b1;
    we      = 1'b0;
    addr    = 32'h800;
    rises   = 0;
    done1   = -1;
    rise2   = -1;
    n_done  = 0;
    prev_rd = 1'b0;
    raddr   = 32'h800;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (mem_rd && !prev_rd) begin
        rises++;
        if (rises == 2) rise2 = j;
        raddr = (rises == 1) ? 32'h800 : 32'h804;
        chk("b2b bus_addr", mem_addr, raddr);
        addr = 32'h804;
        if (rises == 2) start = 1'b0;
      end
      if (done) begin
        n_done++;
        if (done1 < 0) done1 = j;
        chk("b2b rdata", rdata, ref_mem[raddr]);
      end
      prev_rd   = mem_rd;
      mem_ack   = mem_rd;
      mem_rdata = mem_rd ? ref_mem[raddr] : $urandom;
    end
    start   = 1'b0;
    mem_ack = 1'b0;
    chk("b2b rd_pulses", 32'(rises), 32'd2);
    chk("b2b done_pulses", 32'(n_done), 32'd2);
    chk("b2b restart_gap", 32'(rise2 - done1), 32'd2);
    exp_rdata = ref_mem[32'h804];
    exp_err   = 1'b0;

    // Reset while a read strobe is waiting for ACK.
    start = 1'b1;
    we    = 1'b0;
    addr  = 32'h808;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chkb("midreset rd_before", mem_rd, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chkb("midreset rd", mem_rd, 1'b0);
    chkb("midreset busy", busy, 1'b0);
    chkb("midreset done", done, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chkb("midreset no_done_after", done, 1'b0);
    exp_rdata = '0;
    exp_err   = 1'b0;
    run_cmd("after_reset_read", 1'b0, 32'h000, 32'h0, 1, 1'b0);

    // Random commands against the reference model.
    for (int n = 0; n < 30; n++) begin
      logic [31:0] a;
      a = 32'h800 + 32'($urandom_range(0, 7)) * 4;
      if ($urandom_range(0, 4) == 0) a = a + 32'($urandom_range(1, 3));
      run_cmd($sformatf("rand%0d", n), 1'($urandom), a, $urandom,
              int'($urandom_range(1, 20)), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
